// File: rtl/bitvec_scan.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | bitvec_scan : walks an accepted bit vector from bit 0 upward and emits  |
// |               the index of each set bit as a valid/ready beat.          |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
module bitvec_scan #(
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_index,
  output logic             out_last,
  output logic             out_empty,
  output logic [IDXW:0]    ones
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  vec_q, vec_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [IDXW-1:0]   out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic              out_empty_q, out_empty_d;
  logic [IDXW:0]     ones_q, ones_d;
  logic              none_above;

  // True when no set bit remains strictly above the current pointer.
  assign none_above = (((vec_q >> ptr_q) >> 1) == '0);

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    out_empty_d = out_empty_q;
    ones_d      = ones_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          vec_d   = in_data;
          ptr_d   = '0;
          ones_d  = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (vec_q[ptr_q]) begin
          out_index_d = ptr_q;
          out_empty_d = 1'b0;
          out_last_d  = none_above;
          out_valid_d = 1'b1;
          state_d     = S_EMIT;
        end else if (ptr_q == IDXW'(WIDTH - 1)) begin
          // Only reachable when the whole vector was zero.
          out_index_d = '0;
          out_empty_d = 1'b1;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_EMIT;
        end else begin
          ptr_d = ptr_q + IDXW'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!out_empty_q) begin
            ones_d = ones_q + (IDXW+1)'(1);
          end
          if (out_last_q) begin
            state_d = S_IDLE;
          end else begin
            ptr_d   = ptr_q + IDXW'(1);
            state_d = S_SCAN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      out_empty_q <= 1'b0;
      ones_q      <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      out_empty_q <= out_empty_d;
      ones_q      <= ones_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign out_empty = out_empty_q;
  assign ones      = ones_q;

endmodule
`default_nettype wire

// File: tb/tb_bitvec_scan.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_bitvec_scan : directed self-checking bench for bitvec_scan (WIDTH=8) |
// | Revision       : 1.0                                                    |
// +-------------------------------------------------------------------------+
module tb_bitvec_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_index;
  logic       out_last;
  logic       out_empty;
  logic [3:0] ones;

  int compared = 0;
  int mism = 0;
  int cyc = 0;
  int t0 = 0;

  int         b_edge [16];
  logic [2:0] b_idx  [16];
  logic       b_last [16];
  logic       b_empty[16];
  int         nb;

  bitvec_scan #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_last(out_last), .out_empty(out_empty), .ones(ones)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Offer a vector; returns #1 after the accepting edge with t0 set to it.
  task automatic accept(input logic [7:0] v, input logic hold);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk); #1;
    t0 = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  // Records beats with out_ready=1 until the last one has been handed off.
  task automatic collect(input int limit);
    nb = 0;
    out_ready = 1'b1;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      if (out_valid && nb < 16) begin
        b_edge[nb]  = cyc - t0;
        b_idx[nb]   = out_index;
        b_last[nb]  = out_last;
        b_empty[nb] = out_empty;
        nb++;
        if (out_last) begin
          @(posedge clk); #1;
          return;
        end
      end
    end
    compared++; mism++;
    $display("FAIL collect_timeout: got %0d beats, no last beat within %0d cycles", nb, limit);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      compared++;
      if ({in_ready, out_valid, ones, out_index, out_last, out_empty} !== {1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0}) begin
        mism++;
        $display("FAIL reset_state: got rdy=%b vld=%b ones=%0d idx=%0d last=%b empty=%b",
                 in_ready, out_valid, ones, out_index, out_last, out_empty);
      end
    end
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mism++;
      $display("FAIL reset_nothing_accepted: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int   exp_e [4] = '{1, 4, 8, 11};
    int   exp_i [4] = '{0, 2, 5, 7};
    logic exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    accept(8'b1010_0101, 1'b0);
    collect(40);
    compared++;
    if (nb !== 4) begin mism++; $display("FAIL basic_count: got %0d want 4", nb); end
    for (int k = 0; k < 4 && k < nb; k++) begin
      compared++;
      if (b_edge[k] !== exp_e[k] || 32'(b_idx[k]) !== exp_i[k] || b_last[k] !== exp_l[k] || b_empty[k] !== 1'b0) begin
        mism++;
        $display("FAIL basic_beat%0d: got edge=%0d idx=%0d last=%b empty=%b want edge=%0d idx=%0d last=%b empty=0",
                 k, b_edge[k], b_idx[k], b_last[k], b_empty[k], exp_e[k], exp_i[k], exp_l[k]);
      end
    end
    compared++;
    if (ones !== 4'd4 || in_ready !== 1'b1 || (cyc - t0) !== 12) begin
      mism++;
      $display("FAIL basic_done: got ones=%0d rdy=%b edge=%0d want 4 1 12", ones, in_ready, cyc - t0);
    end
  endtask

  task automatic test_zero();
    accept(8'h00, 1'b0);
    collect(40);
    compared++;
    if (nb !== 1 || b_edge[0] !== 8 || b_idx[0] !== 3'd0 || b_last[0] !== 1'b1 || b_empty[0] !== 1'b1) begin
      mism++;
      $display("FAIL zero_beat: got n=%0d edge=%0d idx=%0d last=%b empty=%b want 1 8 0 1 1",
               nb, b_edge[0], b_idx[0], b_last[0], b_empty[0]);
    end
    compared++;
    if (ones !== 4'd0 || in_ready !== 1'b1) begin
      mism++;
      $display("FAIL zero_ones: got ones=%0d rdy=%b want 0 1", ones, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int seen = 0;
    out_ready = 1'b0;
    accept(8'h81, 1'b0);
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = cyc - t0;
    end
    compared++;
    if (seen !== 1 || out_index !== 3'd0) begin
      mism++;
      $display("FAIL bp_first: got edge=%0d idx=%0d want 1 0", seen, out_index);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      compared++;
      if (out_valid !== 1'b1 || out_index !== 3'd0 || out_last !== 1'b0 || ones !== 4'd0) begin
        mism++;
        $display("FAIL bp_hold%0d: got vld=%b idx=%0d last=%b ones=%0d want 1 0 0 0",
                 c, out_valid, out_index, out_last, ones);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (out_valid !== 1'b0 || ones !== 4'd1) begin
      mism++;
      $display("FAIL bp_release: got vld=%b ones=%0d want 0 1", out_valid, ones);
    end
    collect(40);
    compared++;
    if (nb !== 1 || b_idx[0] !== 3'd7 || b_last[0] !== 1'b1 || ones !== 4'd2) begin
      mism++;
      $display("FAIL bp_second: got n=%0d idx=%0d last=%b ones=%0d want 1 7 1 2", nb, b_idx[0], b_last[0], ones);
    end
  endtask

  task automatic test_busy();
    accept(8'h06, 1'b1);
    in_data = 8'hFF;
    collect(40);
    compared++;
    if (nb !== 2 || b_idx[0] !== 3'd1 || b_idx[1] !== 3'd2 || b_last[0] !== 1'b0 || b_last[1] !== 1'b1
        || b_edge[0] !== 2 || b_edge[1] !== 4) begin
      mism++;
      $display("FAIL busy_first: got n=%0d idx=%0d,%0d last=%b,%b edge=%0d,%0d want 2 1,2 0,1 2,4",
               nb, b_idx[0], b_idx[1], b_last[0], b_last[1], b_edge[0], b_edge[1]);
    end
    // in_valid is still high, so the held 8'hFF is taken on the very next edge.
    @(posedge clk); #1;
    t0 = cyc;
    in_valid = 1'b0;
    compared++;
    if (in_ready !== 1'b0) begin mism++; $display("FAIL busy_accept: got rdy=%b want 0", in_ready); end
    collect(60);
    compared++;
    if (nb !== 8) begin mism++; $display("FAIL busy_count: got %0d want 8", nb); end
    for (int k = 0; k < 8 && k < nb; k++) begin
      compared++;
      if (32'(b_idx[k]) !== k || b_edge[k] !== 1 + 2 * k || b_last[k] !== (k == 7)) begin
        mism++;
        $display("FAIL busy_beat%0d: got idx=%0d edge=%0d last=%b want %0d %0d %b",
                 k, b_idx[k], b_edge[k], b_last[k], k, 1 + 2 * k, (k == 7));
      end
    end
    compared++;
    if (ones !== 4'd8) begin mism++; $display("FAIL busy_ones: got %0d want 8", ones); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    accept(8'hFF, 1'b0);
    for (int c = 0; c < 20 && (cyc - t0) < 4; c++) begin
      @(posedge clk); #1;
    end
    compared++;
    if (ones !== 4'd2) begin mism++; $display("FAIL rstmid_pre: got ones=%0d want 2", ones); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ones !== 4'd0) begin
      mism++;
      $display("FAIL rstmid_after: got vld=%b rdy=%b ones=%0d want 0 1 0", out_valid, in_ready, ones);
    end
    @(negedge clk); rst = 1'b0;
    accept(8'h80, 1'b0);
    collect(40);
    compared++;
    if (nb !== 1 || b_idx[0] !== 3'd7 || b_last[0] !== 1'b1 || b_empty[0] !== 1'b0 || b_edge[0] !== 8 || ones !== 4'd1) begin
      mism++;
      $display("FAIL rstmid_next: got n=%0d idx=%0d last=%b empty=%b edge=%0d ones=%0d want 1 7 1 0 8 1",
               nb, b_idx[0], b_last[0], b_empty[0], b_edge[0], ones);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bitvec_scan.md
# bitvec_scan

Sequential bit-vector reader: accepts a WIDTH-bit vector over a valid/ready handshake, walks it from bit 0 upward one position per clock, and emits the index of every set bit as an output beat. It is the read-side counterpart to loop-based bit-setting logic. Downstream consumers get set-bit indices in ascending order without a wide combinational priority encoder.

## Interface
- WIDTH, 8, vector width; WIDTH >= 2.
- IDXW (localparam), $clog2(WIDTH), index width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector offered.
- in_ready  out  1  block can accept a vector; high only in IDLE.
- in_data  in  WIDTH  vector to scan; sampled only on in_valid && in_ready.
- out_valid  out  1  output beat presented.
- out_ready  in  1  downstream accepts beat.
- out_index  out  IDXW  bit position of a set bit; 0 on empty beat.
- out_last  out  1  final beat for current vector.
- out_empty  out  1  beat reports an all-zero vector.
- ones  out  IDXW+1  set bits handed off so far for current vector.

## Operation
- States: IDLE, SCAN, EMIT. Registers: vec[WIDTH], ptr[IDXW], output regs, ones.
- IDLE: in_ready=1. On in_valid: vec<=in_data, ptr<=0, ones<=0, go SCAN.
- SCAN (in_ready=0, out_valid=0), one bit per cycle:
  - vec[ptr]=1: out_index<=ptr, out_empty<=0, out_last<=(vec bits above ptr all zero), out_valid<=1, go EMIT.
  - vec[ptr]=0 and ptr==WIDTH-1: reachable only for an all-zero vector; out_index<=0, out_empty<=1, out_last<=1, out_valid<=1, go EMIT.
  - else ptr<=ptr+1.
- EMIT: out_valid, out_index, out_last, out_empty held stable until out_ready. On handshake: out_valid<=0; if !out_empty, ones<=ones+1; if out_last go IDLE, else ptr<=ptr+1, go SCAN.
- in_data/in_valid ignored outside IDLE; vec is never modified mid-scan.
- ones: no wrap possible (max WIDTH fits IDXW+1 bits); holds its final value in IDLE until next accept.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, out_index=0, out_last=0, out_empty=0, ones=0, ptr=0, vec=0.
- rst mid-operation: vector discarded, any pending beat dropped (no handshake); reset values from the next cycle.
- Accept on edge 0: first set bit k raises out_valid at edge 1+k.
- Handshake at edge h for bit i: next set bit j raises out_valid at edge h+(j-i).
- All-zero vector: single empty beat, out_valid rises at edge WIDTH.
- After last handshake at edge h: in_ready high after edge h, next accept at edge h+1 earliest. No overlap of vectors.
- out_ready low: block stalls in EMIT indefinitely, outputs frozen.
- Outputs are registers; in_ready decodes state only (no combinational in-to-out path).

## Test plan
- Reset: rst high 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, ones=0 throughout; nothing accepted.
- WIDTH=8, in_data=8'b1010_0101 accepted at edge 0, out_ready=1 -> beats at edges 1,4,8,11 with index 0,2,5,7; out_last only on 7; handshake edges 2,5,9,12; ones=4; in_ready high after edge 12.
- in_data=8'h00 -> one beat at edge 8: out_empty=1, out_last=1, out_index=0; ones stays 0.
- Backpressure: in_data=8'h81, out_ready=0 for 5 cycles after out_valid -> index 0 held stable, ptr frozen; release -> indices 0 then 7 (last), ones=2.
- Input during busy: accept 8'h06, drive in_valid=1, in_data=8'hFF during scan -> only indices 1,2 emitted; 8'hFF accepted only after return to IDLE, then 8 beats 0..7.
- Reset mid-scan: 8'hFF, assert rst after second handshake -> next cycle out_valid=0, in_ready=1, ones=0; then 8'h80 -> single beat index 7, out_last=1 at edge 8 after accept.
